// File: rtl/switch_mode_ctrl_pkg.sv
// Shared types and constants for the switch-to-mode control stage.
package switch_mode_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RELEASED  = 2'd0,
        S_PRESSED   = 2'd1,
        S_LONG_HELD = 2'd2
    } press_state_e;

    localparam int c_MODE_W  = 3;
    localparam int c_LED_NUM = 4;

    // Thermometer decode: mode m lights the lower m LEDs; out-of-range modes light all.
    function automatic logic [c_LED_NUM-1:0] mode_to_led(input logic [c_MODE_W-1:0] mode);
        logic [c_LED_NUM-1:0] led;
        led = '0;
        for (int i = 0; i < c_LED_NUM; i++) begin
            led[i] = (mode > c_MODE_W'(i));
        end
        return led;
    endfunction

endpackage

// File: rtl/switch_mode_ctrl_debounce_filter.sv
// Two-flop synchroniser followed by a counter that accepts a new level only after
// it has been stable for g_DEBOUNCE_LIMIT consecutive cycles.
module debounce_filter #(
    parameter int unsigned g_DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Raw,
    output logic o_Db
);

    logic        sync1_q;
    logic        sync2_q;
    logic        db_q;
    logic        db_d;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == 32'(g_DEBOUNCE_LIMIT - 1)) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= i_Raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_Db = db_q;

endmodule

// File: rtl/switch_mode_ctrl.sv
// Debounced push switch classified into short presses (step mode) and long presses
// (return to mode 0); the mode drives a registered thermometer LED-enable vector.
module switch_mode_ctrl
    import switch_mode_ctrl_pkg::*;
#(
    parameter int unsigned g_DEBOUNCE_LIMIT = 250000,
    parameter int unsigned g_LONG_PRESS     = 25000000,
    parameter int unsigned g_NUM_MODES      = 5
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_Switch,
    output logic                  o_Switch_Db,
    output logic [c_MODE_W-1:0]   o_Mode,
    output logic                  o_Mode_Change,
    output logic                  o_Long_Press,
    output logic [c_LED_NUM-1:0]  o_LED_En
);

    press_state_e         state_q, state_d;
    logic [31:0]          hold_q, hold_d;
    logic [c_MODE_W-1:0]  mode_q, mode_d;
    logic                 change_q, change_d;
    logic                 long_q, long_d;
    logic [c_LED_NUM-1:0] led_q;
    logic                 db;
    logic                 db_prev_q;
    logic                 rise;
    logic                 fall;

    debounce_filter #(
        .g_DEBOUNCE_LIMIT(g_DEBOUNCE_LIMIT)
    ) u_debounce (
        .i_Clk  (i_Clk),
        .i_Rst_L(i_Rst_L),
        .i_Raw  (i_Switch),
        .o_Db   (db)
    );

    assign rise = db & ~db_prev_q;
    assign fall = ~db & db_prev_q;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        mode_d   = mode_q;
        change_d = 1'b0;
        long_d   = 1'b0;
        case (state_q)
            S_RELEASED: begin
                if (rise) begin
                    hold_d  = '0;
                    state_d = S_PRESSED;
                end
            end
            S_PRESSED: begin
                // A release on the threshold cycle still counts as a short press.
                if (fall) begin
                    mode_d   = (mode_q == c_MODE_W'(g_NUM_MODES - 1)) ? '0 : mode_q + 1'b1;
                    change_d = 1'b1;
                    state_d  = S_RELEASED;
                end else if (hold_q == 32'(g_LONG_PRESS - 1)) begin
                    mode_d   = '0;
                    change_d = 1'b1;
                    long_d   = 1'b1;
                    state_d  = S_LONG_HELD;
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end
            S_LONG_HELD: begin
                if (fall) begin
                    state_d = S_RELEASED;
                end
            end
            default: begin
                state_d = S_RELEASED;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= S_RELEASED;
            hold_q    <= '0;
            mode_q    <= '0;
            change_q  <= 1'b0;
            long_q    <= 1'b0;
            led_q     <= '0;
            db_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            mode_q    <= mode_d;
            change_q  <= change_d;
            long_q    <= long_d;
            led_q     <= mode_to_led(mode_q);
            db_prev_q <= db;
        end
    end

    assign o_Switch_Db   = db;
    assign o_Mode        = mode_q;
    assign o_Mode_Change = change_q;
    assign o_Long_Press  = long_q;
    assign o_LED_En      = led_q;

endmodule
